// File: rtl/gantry_move_sequencer.sv
// Sequencer for the XY stepper gantry and electromagnet that slides Klotski blocks.
// Accepts one-cell move commands (source cell + direction) over valid/ready. For each
// command the head travels empty to the source cell, energises the magnet, drags the
// block one cell, releases it, and then reports completion. It also tracks the head position.
// Ports:
//   i_Clk, i_rst_n             clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready  command handshake (ready only in IDLE)
//   i_cmd_home                 return the head to (0,0); src/dir are ignored
//   i_src_x, i_src_y, i_dir    source cell and drag direction (0 up, 1 down, 2 left, 3 right)
//   o_step_*, o_direction_*    stepper pulse and direction pins (direction 1 = positive axis)
//   o_magnet                   electromagnet enable
//   o_busy, o_done, o_err      status; done/err are single-cycle pulses
//   o_pos_x, o_pos_y           current head cell
module gantry_move_sequencer #(
  parameter int unsigned GRID_W     = 4,
  parameter int unsigned GRID_H     = 5,
  parameter int unsigned CELL_STEPS = 200,
  parameter int unsigned STEP_HALF  = 250,
  parameter int unsigned MAG_SETTLE = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_home,
  input  logic [2:0] i_src_x,
  input  logic [2:0] i_src_y,
  input  logic [1:0] i_dir,
  output logic       o_step_x,
  output logic       o_direction_x,
  output logic       o_step_y,
  output logic       o_direction_y,
  output logic       o_magnet,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [2:0] o_pos_x,
  output logic [2:0] o_pos_y
);

  localparam int unsigned MAXD = (GRID_W > GRID_H) ? GRID_W : GRID_H;
  localparam int unsigned SW   = $clog2(MAXD * CELL_STEPS + 1);
  localparam int unsigned WMAX = (MAG_SETTLE > STEP_HALF) ? MAG_SETTLE : STEP_HALF;
  localparam int unsigned WW   = $clog2(WMAX + 1);
  localparam logic [SW-1:0] CS_W   = SW'(CELL_STEPS);
  localparam logic [WW-1:0] H_LAST = WW'(STEP_HALF - 1);
  localparam logic [WW-1:0] S_LAST = WW'(MAG_SETTLE - 1);
  localparam logic [3:0]    GW4    = 4'(GRID_W);
  localparam logic [3:0]    GH4    = 4'(GRID_H);

  typedef enum logic [2:0] {
    IDLE, DECODE, TRAV_X, TRAV_Y, MAG_ON, DRAG, MAG_OFF, DONE
  } state_t;

  state_t state, state_next;

  logic          home_q, err_q, dir_x_q, dir_y_q, step_lvl;
  logic [2:0]    src_x_q, src_y_q, pos_x, pos_y;
  logic [1:0]    dir_q;
  logic [SW-1:0] nx_steps, ny_steps, step_cnt, step_tgt;
  logic [WW-1:0] wait_cnt;

  logic [2:0] nx, ny, dest_x, dest_y;
  logic       off_board, reject, half_end, wait_end, phase_end;

  // Distances, destination and rejection are derived from the latched command.
  always_comb begin
    nx = (src_x_q > pos_x) ? (src_x_q - pos_x) : (pos_x - src_x_q);
    ny = (src_y_q > pos_y) ? (src_y_q - pos_y) : (pos_y - src_y_q);
    dest_x    = src_x_q;
    dest_y    = src_y_q;
    off_board = 1'b0;
    case (dir_q)
      2'd0: begin off_board = (src_y_q == 3'd0);                dest_y = src_y_q - 3'd1; end
      2'd1: begin off_board = ({1'b0, src_y_q} == GH4 - 4'd1);  dest_y = src_y_q + 3'd1; end
      2'd2: begin off_board = (src_x_q == 3'd0);                dest_x = src_x_q - 3'd1; end
      default: begin off_board = ({1'b0, src_x_q} == GW4 - 4'd1); dest_x = src_x_q + 3'd1; end
    endcase
    reject = !home_q &&
             (({1'b0, src_x_q} >= GW4) || ({1'b0, src_y_q} >= GH4) || off_board);
  end

  // Step-phase length depends on which phase is running.
  always_comb begin
    case (state)
      TRAV_X:  step_tgt = nx_steps;
      TRAV_Y:  step_tgt = ny_steps;
      default: step_tgt = CS_W;
    endcase
    half_end  = (wait_cnt == H_LAST);
    wait_end  = (wait_cnt == S_LAST);
    phase_end = step_lvl && half_end && (step_cnt == step_tgt - 1'b1);
  end

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Zero-length travel phases are skipped outright so they cost no cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_cmd_valid) state_next = DECODE;
      DECODE: begin
        if (reject)          state_next = DONE;
        else if (nx != 3'd0) state_next = TRAV_X;
        else if (ny != 3'd0) state_next = TRAV_Y;
        else if (home_q)     state_next = DONE;
        else                 state_next = MAG_ON;
      end
      TRAV_X: if (phase_end) begin
        if (ny_steps != '0) state_next = TRAV_Y;
        else if (home_q)    state_next = DONE;
        else                state_next = MAG_ON;
      end
      TRAV_Y:  if (phase_end) state_next = home_q ? DONE : MAG_ON;
      MAG_ON:  if (wait_end)  state_next = DRAG;
      DRAG:    if (phase_end) state_next = MAG_OFF;
      MAG_OFF: if (wait_end)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      home_q   <= 1'b0;
      err_q    <= 1'b0;
      src_x_q  <= '0;
      src_y_q  <= '0;
      dir_q    <= '0;
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
      pos_x    <= '0;
      pos_y    <= '0;
      nx_steps <= '0;
      ny_steps <= '0;
      step_cnt <= '0;
      wait_cnt <= '0;
      step_lvl <= 1'b0;
    end else begin
      if (state == IDLE && i_cmd_valid) begin
        home_q  <= i_cmd_home;
        src_x_q <= i_cmd_home ? 3'd0 : i_src_x;
        src_y_q <= i_cmd_home ? 3'd0 : i_src_y;
        dir_q   <= i_dir;
      end
      if (state == DECODE) begin
        nx_steps <= SW'(nx) * CS_W;
        ny_steps <= SW'(ny) * CS_W;
        err_q    <= reject;
        if (!reject) begin
          dir_x_q <= (src_x_q > pos_x);
          dir_y_q <= (src_y_q > pos_y);
        end
      end
      // Drag direction is set on DRAG entry, while the step line is still low.
      if (state == MAG_ON && state_next == DRAG) begin
        case (dir_q)
          2'd0:    dir_y_q <= 1'b0;
          2'd1:    dir_y_q <= 1'b1;
          2'd2:    dir_x_q <= 1'b0;
          default: dir_x_q <= 1'b1;
        endcase
      end
      if (state == DONE && !err_q) begin
        pos_x <= home_q ? 3'd0 : dest_x;
        pos_y <= home_q ? 3'd0 : dest_y;
      end
      // Every state change restarts the half-period/settle timer with step low.
      if (state_next != state) begin
        wait_cnt <= '0;
        step_cnt <= '0;
        step_lvl <= 1'b0;
      end else begin
        case (state)
          TRAV_X, TRAV_Y, DRAG: begin
            if (half_end) begin
              wait_cnt <= '0;
              step_lvl <= !step_lvl;
              if (step_lvl) step_cnt <= step_cnt + 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          MAG_ON, MAG_OFF: wait_cnt <= wait_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_cmd_ready = (state == IDLE);
    o_busy      = (state != IDLE);
    o_magnet    = (state == MAG_ON) || (state == DRAG);
    o_done      = (state == DONE);
    o_err       = (state == DONE) && err_q;
    o_step_x    = step_lvl && ((state == TRAV_X) || ((state == DRAG) &&  dir_q[1]));
    o_step_y    = step_lvl && ((state == TRAV_Y) || ((state == DRAG) && !dir_q[1]));
  end

  assign o_direction_x = dir_x_q;
  assign o_direction_y = dir_y_q;
  assign o_pos_x       = pos_x;
  assign o_pos_y       = pos_y;

endmodule

// File: tb/tb_gantry_move_sequencer.sv
// Directed bench for gantry_move_sequencer with CELL_STEPS=2, STEP_HALF=2, MAG_SETTLE=3,
// so one cell of travel is 8 cycles and each magnet settle is 3 cycles.
module tb_gantry_move_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_home;
  logic [2:0] src_x, src_y;
  logic [1:0] dir;
  logic       cmd_ready, step_x, direction_x, step_y, direction_y;
  logic       magnet, busy, done, err;
  logic [2:0] pos_x, pos_y;

  int n_cmp = 0;
  int n_bad = 0;

  // Results of the most recent watch()
  int lat, xp, xn, yp, yn, mag, both, seen, errf;

  gantry_move_sequencer #(
    .GRID_W(4), .GRID_H(5), .CELL_STEPS(2), .STEP_HALF(2), .MAG_SETTLE(3)
  ) dut (
    .i_Clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_home(cmd_home),
    .i_src_x(src_x), .i_src_y(src_y), .i_dir(dir),
    .o_step_x(step_x), .o_direction_x(direction_x),
    .o_step_y(step_y), .o_direction_y(direction_y),
    .o_magnet(magnet), .o_busy(busy), .o_done(done), .o_err(err),
    .o_pos_x(pos_x), .o_pos_y(pos_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Follows one command from just after its accept edge until o_done, counting
  // step pulses by direction, magnet-on cycles and edges to completion.
  task automatic watch();
    logic px, py;
    px = 1'b0; py = 1'b0;
    lat = 0; xp = 0; xn = 0; yp = 0; yn = 0; mag = 0; both = 0; seen = 0; errf = 0;
    for (int i = 0; i < 400 && seen == 0; i++) begin
      @(posedge clk); #1;
      lat++;
      if (step_x && !px) begin
        if (direction_x) xp++; else xn++;
      end
      if (step_y && !py) begin
        if (direction_y) yp++; else yn++;
      end
      if (magnet) mag++;
      if (step_x && step_y) both++;
      if (done) begin
        seen = 1;
        errf = int'(err);
      end
      px = step_x; py = step_y;
    end
  endtask

  task automatic issue(input logic h, input logic [2:0] sx, input logic [2:0] sy, input logic [1:0] d);
    int w;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("ready_before_cmd", int'(cmd_ready), 1);
    cmd_home = h; src_x = sx; src_y = sy; dir = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    check("ready_low_when_busy", int'(cmd_ready), 0);
  endtask

  task automatic expect_cmd(input int e_lat, input int e_xp, input int e_xn, input int e_yp,
                            input int e_yn, input int e_mag, input int e_err,
                            input int e_px, input int e_py);
    check("done_seen", seen, 1);
    check("latency", lat, e_lat);
    check("step_x_pos", xp, e_xp);
    check("step_x_neg", xn, e_xn);
    check("step_y_pos", yp, e_yp);
    check("step_y_neg", yn, e_yn);
    check("magnet_cycles", mag, e_mag);
    check("steps_overlap", both, 0);
    check("err_pulse", errf, e_err);
    @(posedge clk); #1;
    check("done_one_cycle", int'(done), 0);
    check("ready_after_done", int'(cmd_ready), 1);
    check("pos_x", int'(pos_x), e_px);
    check("pos_y", int'(pos_y), e_py);
  endtask

  initial begin
    int found, extra;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_home = 1'b0;
    src_x = '0; src_y = '0; dir = '0;
    #1;
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_magnet", int'(magnet), 0);
    check("rst_steps", int'({step_x, step_y}), 0);
    check("rst_dirs", int'({direction_x, direction_y}), 0);
    check("rst_done_err", int'({done, err}), 0);
    check("rst_pos", int'({pos_x, pos_y}), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: (0,0) -> src (1,0), drag right: 1 + 8*2 + 6
    issue(1'b0, 3'd1, 3'd0, 2'd3); watch();
    expect_cmd(23, 4, 0, 0, 0, 11, 0, 2, 0);

    // 2: (2,0) -> src (0,1), drag down: 1 + 8*(2+1+1) + 6
    issue(1'b0, 3'd0, 3'd1, 2'd1); watch();
    expect_cmd(39, 0, 4, 4, 0, 11, 0, 0, 2);

    // 3: rejected commands leave position alone
    issue(1'b0, 3'd3, 3'd4, 2'd3); watch();
    expect_cmd(1, 0, 0, 0, 0, 0, 1, 0, 2);
    issue(1'b0, 3'd4, 3'd0, 2'd3); watch();
    expect_cmd(1, 0, 0, 0, 0, 0, 1, 0, 2);

    // Get to (2,3): (0,2) -> src (2,2), drag down: 1 + 8*3 + 6
    issue(1'b0, 3'd2, 3'd2, 2'd1); watch();
    expect_cmd(31, 4, 0, 2, 0, 11, 0, 2, 3);

    // 4: home from (2,3): 1 + 8*5, magnet never on; src/dir fields ignored
    issue(1'b1, 3'd7, 3'd7, 2'd0); watch();
    expect_cmd(41, 0, 4, 0, 6, 0, 0, 0, 0);

    // 5: valid held through busy with the next command already presented
    cmd_home = 1'b0; src_x = 3'd0; src_y = 3'd0; dir = 2'd3; cmd_valid = 1'b1;
    @(posedge clk); #1;
    check("hold_accept_busy", int'(busy), 1);
    src_x = 3'd1; src_y = 3'd0; dir = 2'd1;
    watch();
    expect_cmd(15, 2, 0, 0, 0, 11, 0, 1, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("hold_second_accepted", int'(busy), 1);
    watch();
    expect_cmd(15, 0, 0, 2, 0, 11, 0, 1, 1);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("no_extra_done", extra, 0);

    // 6: reset asserted in the middle of a drag
    issue(1'b0, 3'd1, 3'd1, 2'd2);
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(posedge clk); #1;
      if (magnet && step_x) found = 1;
    end
    check("reached_drag", found, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_magnet", int'(magnet), 0);
    check("midrst_steps", int'({step_x, step_y}), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(cmd_ready), 1);
    check("midrst_pos", int'({pos_x, pos_y}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // After reset, (0,0) dragged up is off-board
    issue(1'b0, 3'd0, 3'd0, 2'd0); watch();
    expect_cmd(1, 0, 0, 0, 0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
